// File: rtl/response_generator_if.sv
// Request-FIFO, cache-memory, AXI R/B and miss-notification signals of the response generator.
// master is the response_generator side, slave is the surrounding fabric or bench.
interface response_generator_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 16,
  parameter int INDEX_WIDTH = 4
);
  logic                              fifo_empty_i;
  logic [ADDR_WIDTH+ID_WIDTH:0]      fifo_data_i;
  logic                              fifo_read_en_o;
  logic                              mem_rd_en_o;
  logic [INDEX_WIDTH-1:0]            mem_index_o;
  logic                              mem_valid_i;
  logic [ADDR_WIDTH-INDEX_WIDTH-1:0] mem_tag_i;
  logic [DATA_WIDTH-1:0]             mem_rdata_i;
  logic [ID_WIDTH-1:0]               rid_o;
  logic [DATA_WIDTH-1:0]             rdata_o;
  logic [1:0]                        rresp_o;
  logic                              rlast_o;
  logic                              rvalid_o;
  logic                              rready_i;
  logic [ID_WIDTH-1:0]               bid_o;
  logic [1:0]                        bresp_o;
  logic                              bvalid_o;
  logic                              bready_i;
  logic                              miss_valid_o;
  logic [ADDR_WIDTH-1:0]             miss_addr_o;
  logic [31:0]                       hit_count_o;
  logic [31:0]                       miss_count_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, mem_valid_i, mem_tag_i, mem_rdata_i, rready_i, bready_i,
    output fifo_read_en_o, mem_rd_en_o, mem_index_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
           bid_o, bresp_o, bvalid_o, miss_valid_o, miss_addr_o, hit_count_o, miss_count_o
  );
  modport slave (
    output fifo_empty_i, fifo_data_i, mem_valid_i, mem_tag_i, mem_rdata_i, rready_i, bready_i,
    input  fifo_read_en_o, mem_rd_en_o, mem_index_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o,
           bid_o, bresp_o, bvalid_o, miss_valid_o, miss_addr_o, hit_count_o, miss_count_o
  );
endinterface

// File: rtl/response_generator.sv
// Pops one request at a time, looks it up in the cache memory and returns a single AXI R or B beat.
// Define RESP_STATS_EN to build the saturating hit/miss statistics counters.
module response_generator #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int MEM_LATENCY = 2
) (
  input logic clk,
  input logic rst,
  response_generator_if.master bus
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("response_generator: MEM_LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  rw_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  pop, sample, hshk, hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // pop is gated by rst so no entry is lost while the datapath is held in reset
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    sample    = 1'b0;
    hshk      = 1'b0;
    case (state)
      S_IDLE:   if (!bus.fifo_empty_i && !rst) begin pop = 1'b1; state_nxt = S_LOOKUP; end
      S_LOOKUP: if (cnt == 4'd0) begin sample = 1'b1; state_nxt = S_RESP; end
      S_RESP:   if ((bus.rvalid_o && bus.rready_i) || (bus.bvalid_o && bus.bready_i)) begin
                  hshk = 1'b1; state_nxt = S_IDLE;
                end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.fifo_read_en_o = pop;
  assign bus.mem_rd_en_o    = pop;
  assign bus.mem_index_o    = pop ? bus.fifo_data_i[INDEX_WIDTH-1:0] : '0;
  assign hit = bus.mem_valid_i && (bus.mem_tag_i == addr_q[ADDR_WIDTH-1:INDEX_WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= '0;
      rw_q             <= 1'b0;
      id_q             <= '0;
      addr_q           <= '0;
      bus.rid_o        <= '0;
      bus.rdata_o      <= '0;
      bus.rresp_o      <= '0;
      bus.rlast_o      <= 1'b0;
      bus.rvalid_o     <= 1'b0;
      bus.bid_o        <= '0;
      bus.bresp_o      <= '0;
      bus.bvalid_o     <= 1'b0;
      bus.miss_valid_o <= 1'b0;
      bus.miss_addr_o  <= '0;
    end else begin
      bus.miss_valid_o <= 1'b0;
      if (pop) begin
        rw_q   <= bus.fifo_data_i[ADDR_WIDTH+ID_WIDTH];
        id_q   <= bus.fifo_data_i[ADDR_WIDTH+ID_WIDTH-1:ADDR_WIDTH];
        addr_q <= bus.fifo_data_i[ADDR_WIDTH-1:0];
        // memory outputs are valid MEM_LATENCY cycles after the strobe
        cnt    <= 4'(MEM_LATENCY - 1);
      end else if (state == S_LOOKUP && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        if (!rw_q) begin
          bus.rvalid_o <= 1'b1;
          bus.rid_o    <= id_q;
          bus.rdata_o  <= hit ? bus.mem_rdata_i : '0;
          bus.rresp_o  <= hit ? 2'b00 : 2'b10;
          bus.rlast_o  <= 1'b1;
        end else begin
          bus.bvalid_o <= 1'b1;
          bus.bid_o    <= id_q;
          bus.bresp_o  <= hit ? 2'b00 : 2'b10;
        end
        bus.miss_valid_o <= !hit;
        bus.miss_addr_o  <= addr_q;
      end
      if (hshk) begin
        bus.rvalid_o <= 1'b0;
        bus.bvalid_o <= 1'b0;
      end
    end
  end

`ifdef RESP_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (sample) begin
      if (hit && hit_cnt != 32'hFFFF_FFFF)    hit_cnt  <= hit_cnt + 32'd1;
      if (!hit && miss_cnt != 32'hFFFF_FFFF)  miss_cnt <= miss_cnt + 32'd1;
    end
  end
  assign bus.hit_count_o  = hit_cnt;
  assign bus.miss_count_o = miss_cnt;
`else
  assign bus.hit_count_o  = '0;
  assign bus.miss_count_o = '0;
`endif
endmodule

// File: tb/tb_response_generator.sv
// Directed and random requests against a cycle-level scoreboard of the response generator.
module tb_response_generator;
  localparam int AW = 64, DW = 32, IDW = 16, XW = 4, L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  response_generator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .INDEX_WIDTH(XW)) bus();
  response_generator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .INDEX_WIDTH(XW),
                       .MEM_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [80:0] q[$];
  logic [80:0] pend[$];
  logic        mv[16];
  logic [59:0] mt[16];
  logic [31:0] md[16];
  logic        vp[1:L];
  logic [3:0]  ip[1:L];
  int          cyc, t0;
  bit          outst, counted, e_rw, e_miss;
  logic [15:0] e_id;
  logic [31:0] e_data;
  logic [1:0]  e_resp;
  logic [63:0] e_addr;
  int unsigned e_hits, e_misses;
  bit          nr, nb;
  int          vectors = 0, errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [3:0] j;
    j = ip[L];
    bus.fifo_empty_i = (q.size() == 0);
    bus.fifo_data_i  = (q.size() == 0) ? 81'd0 : q[0];
    // memory outputs are only meaningful in the cycle the lookup samples them
    bus.mem_valid_i  = vp[L] ? mv[j] : ~mv[j];
    bus.mem_tag_i    = vp[L] ? mt[j] : ~mt[j];
    bus.mem_rdata_i  = vp[L] ? md[j] : ~md[j];
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_pop"}, bus.fifo_read_en_o, 0);
    chk({tag, "_rd_en"}, bus.mem_rd_en_o, 0);
    chk({tag, "_index"}, bus.mem_index_o, 0);
    chk({tag, "_rvalid"}, bus.rvalid_o, 0);
    chk({tag, "_bvalid"}, bus.bvalid_o, 0);
    chk({tag, "_rpayload"}, {bus.rid_o, bus.rdata_o, bus.rresp_o, bus.rlast_o}, 0);
    chk({tag, "_bpayload"}, {bus.bid_o, bus.bresp_o}, 0);
    chk({tag, "_miss"}, bus.miss_valid_o, 0);
    chk({tag, "_miss_addr"}, bus.miss_addr_o, 0);
    chk({tag, "_counts"}, {bus.hit_count_o, bus.miss_count_o}, 0);
  endtask

  task automatic check_cycle();
    bit exp_pop, exp_valid, first;
    exp_pop = (q.size() > 0) && !outst;
    chk("pop", bus.fifo_read_en_o, exp_pop);
    chk("rd_en", bus.mem_rd_en_o, exp_pop);
    if (exp_pop) chk("index", bus.mem_index_o, q[0][3:0]);
    first = outst && (cyc == t0 + L + 1);
    if (first && !counted) begin
      counted = 1;
      if (e_miss) e_misses++; else e_hits++;
    end
    exp_valid = outst && (cyc >= t0 + L + 1);
    chk("rvalid", bus.rvalid_o, exp_valid && !e_rw);
    chk("bvalid", bus.bvalid_o, exp_valid && e_rw);
    if (exp_valid && !e_rw) begin
      chk("rid", bus.rid_o, e_id);
      chk("rdata", bus.rdata_o, e_data);
      chk("rresp", bus.rresp_o, e_resp);
      chk("rlast", bus.rlast_o, 1);
    end
    if (exp_valid && e_rw) begin
      chk("bid", bus.bid_o, e_id);
      chk("bresp", bus.bresp_o, e_resp);
    end
    chk("miss_valid", bus.miss_valid_o, first && e_miss);
    if (first && e_miss) chk("miss_addr", bus.miss_addr_o, e_addr);
`ifdef RESP_STATS_EN
    chk("hit_count", bus.hit_count_o, e_hits);
    chk("miss_count", bus.miss_count_o, e_misses);
`else
    chk("hit_count", bus.hit_count_o, 0);
    chk("miss_count", bus.miss_count_o, 0);
`endif
  endtask

  task automatic step();
    bit pop_d, rd_d, hs, hit;
    logic [3:0]  ix;
    logic [80:0] e;
    check_cycle();
    pop_d = bus.fifo_read_en_o;
    rd_d  = bus.mem_rd_en_o;
    ix    = bus.mem_index_o;
    hs    = outst && (cyc >= t0 + L + 1) && (e_rw ? bus.bready_i : bus.rready_i);
    @(posedge clk); #1; cyc++;
    if (hs) outst = 0;
    if (pop_d && q.size() > 0) begin
      e       = q.pop_front();
      hit     = mv[e[3:0]] && (mt[e[3:0]] == e[63:4]);
      e_rw    = e[80];
      e_id    = e[79:64];
      e_addr  = e[63:0];
      e_data  = hit ? md[e[3:0]] : 32'd0;
      e_resp  = hit ? 2'b00 : 2'b10;
      e_miss  = !hit;
      t0      = cyc - 1;
      counted = 0;
      outst   = 1;
    end
    for (int k = L; k > 1; k--) begin vp[k] = vp[k-1]; ip[k] = ip[k-1]; end
    vp[1] = rd_d;
    ip[1] = ix;
    while (pend.size() > 0) q.push_back(pend.pop_front());
    bus.rready_i = nr;
    bus.bready_i = nb;
    drive();
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [63:0] r;
    logic [3:0]  idx;
    logic [59:0] tag;
    int pushed;
    bit found;
    for (int i = 0; i < 16; i++) begin mv[i] = 0; mt[i] = '0; md[i] = '0; end
    for (int k = 1; k <= L; k++) begin vp[k] = 0; ip[k] = '0; end
    cyc = 0; t0 = 0; outst = 0; counted = 0; e_rw = 0; e_miss = 0;
    e_id = '0; e_data = '0; e_resp = '0; e_addr = '0; e_hits = 0; e_misses = 0;
    nr = 1; nb = 1;
    bus.rready_i = 1; bus.bready_i = 1;
    drive();
    @(negedge clk);
    check_zero("reset");
    rst = 0;

    // read hit
    mv[3] = 1; mt[3] = 60'h123; md[3] = 32'hDEAD_BEEF;
    pend.push_back({1'b0, 16'h0005, 64'h0000_0000_0000_1233});
    steps(7);
    // write miss
    mv[0] = 0;
    pend.push_back({1'b1, 16'h00A0, 64'h40});
    steps(7);
    // backpressure with more work queued behind
    nr = 0; nb = 0;
    pend.push_back({1'b0, 16'h0011, 64'h1233});
    pend.push_back({1'b1, 16'h0012, 64'h1233});
    steps(14);
    nr = 1; nb = 1;
    steps(12);
    // back-to-back mixed entries
    mv[5] = 1; mt[5] = 60'hABC; md[5] = 32'h1357_9BDF;
    pend.push_back({1'b0, 16'h0101, 64'hABC5});
    pend.push_back({1'b1, 16'h0102, 64'hABC5});
    pend.push_back({1'b0, 16'h0103, 64'h7775});
    pend.push_back({1'b1, 16'h0104, 64'h1233});
    steps(20);
    // reset while the lookup is in flight
    pend.push_back({1'b0, 16'h0201, 64'h1233});
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = outst && (cyc == t0 + 1);
    end
    chk("reach_lookup", found, 1);
    rst = 1;
    #1 check_zero("rst_mid");
    #1 rst = 0;
    outst = 0; e_hits = 0; e_misses = 0;
    for (int k = 1; k <= L; k++) vp[k] = 0;
    drive();
    pend.push_back({1'b1, 16'h0202, 64'hABC5});
    steps(8);

    // random traffic against a fixed random memory image
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom};
      mv[i] = r[63]; mt[i] = r[59:0]; md[i] = $urandom;
    end
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pushed == 40 && q.size() == 0 && pend.size() == 0 && !outst) break;
      if (pushed < 40 && $urandom_range(2, 0) == 0) begin
        idx = 4'($urandom_range(15, 0));
        r   = {$urandom, $urandom};
        tag = ($urandom_range(1, 0) == 1) ? mt[idx] : r[59:0];
        pend.push_back({r[63], 16'($urandom), tag, idx});
        pushed++;
      end
      nr = ($urandom_range(9, 0) < 7);
      nb = ($urandom_range(9, 0) < 7);
      step();
    end
    chk("drain", {outst, q.size() != 0, pend.size() != 0}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
